// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg
// Shared definitions for the accumulator CPU core: default widths,
// opcode encodings and the controller state type.
// Optional feature macro: ACC_CPU_ROTATE_EN enables the rotate-through-carry
// opcodes (C = ROL, D = ROR); without it those encodings are illegal.
package acc_cpu_pkg;

  localparam int ACC_DATA_W_DEF = 8;
  localparam int ACC_ADDR_W_DEF = 4;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_LOADI = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_NOT   = 4'h8;
  localparam logic [3:0] OP_SHL   = 4'h9;
  localparam logic [3:0] OP_SHR   = 4'hA;
  localparam logic [3:0] OP_ADDM  = 4'hB;
  localparam logic [3:0] OP_ROL   = 4'hC;
  localparam logic [3:0] OP_ROR   = 4'hD;

  // Controller state; plain vector with named constants so the encoding
  // stays visible in waveforms and netlists.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/acc_cpu_if.sv
// acc_cpu_if
// Instruction handshake and architectural status bundle of the core.
//   instr_valid/instr_ready : instruction handshake
//   instr_op/operand/addr   : opcode, immediate, scratch-memory address
//   acc_out, flag_c, flag_z : accumulator and flags (registered)
//   done, err               : completion pulse, illegal-opcode indication
// Modports: master = instruction producer, slave = the core.
interface acc_cpu_if
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W_DEF,
  parameter int ADDR_W = ACC_ADDR_W_DEF
);

  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        instr_op;
  logic [DATA_W-1:0] instr_operand;
  logic [ADDR_W-1:0] instr_addr;
  logic [DATA_W-1:0] acc_out;
  logic              flag_c;
  logic              flag_z;
  logic              done;
  logic              err;

  modport master (
    output instr_valid, instr_op, instr_operand, instr_addr,
    input  instr_ready, acc_out, flag_c, flag_z, done, err
  );

  modport slave (
    input  instr_valid, instr_op, instr_operand, instr_addr,
    output instr_ready, acc_out, flag_c, flag_z, done, err
  );

endinterface

// File: rtl/acc_cpu_alu.sv
// acc_cpu_alu
// Purely combinational datapath: computes the next accumulator value and
// carry for one instruction, and flags undefined opcodes.
//   op_i      : opcode
//   acc_i     : current accumulator
//   operand_i : immediate operand
//   mem_i     : scratch-memory word at the instruction address
//   carry_i   : current carry flag
//   result_o  : new accumulator value (acc_i for non-writing ops)
//   carry_o   : new carry flag (carry_i where carry is preserved)
//   illegal_o : opcode undefined in this build
// Optional feature macro: ACC_CPU_ROTATE_EN (opcodes C/D rotate through carry).
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W_DEF
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] operand_i,
  input  logic [DATA_W-1:0] mem_i,
  input  logic              carry_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              illegal_o
);

  // One extra bit holds carry-out for additions and borrow for subtraction.
  logic [DATA_W:0] ext;

  always_comb begin
    ext       = '0;
    result_o  = acc_i;
    carry_o   = carry_i;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        ext      = {1'b0, acc_i} + {1'b0, operand_i};
        result_o = ext[DATA_W-1:0];
        carry_o  = ext[DATA_W];
      end
      OP_SUB: begin
        ext      = {1'b0, acc_i} - {1'b0, operand_i};
        result_o = ext[DATA_W-1:0];
        carry_o  = ext[DATA_W];
      end
      OP_STORE: result_o = acc_i;
      OP_LOAD:  result_o = mem_i;
      OP_LOADI: result_o = operand_i;
      OP_AND:   result_o = acc_i & operand_i;
      OP_OR:    result_o = acc_i | operand_i;
      OP_XOR:   result_o = acc_i ^ operand_i;
      OP_NOT:   result_o = ~acc_i;
      OP_SHL: begin
        result_o = {acc_i[DATA_W-2:0], 1'b0};
        carry_o  = acc_i[DATA_W-1];
      end
      OP_SHR: begin
        result_o = {1'b0, acc_i[DATA_W-1:1]};
        carry_o  = acc_i[0];
      end
      OP_ADDM: begin
        ext      = {1'b0, acc_i} + {1'b0, mem_i};
        result_o = ext[DATA_W-1:0];
        carry_o  = ext[DATA_W];
      end
`ifdef ACC_CPU_ROTATE_EN
      // Rotates treat {carry, acc} as one DATA_W+1 bit ring.
      OP_ROL: begin
        result_o = {acc_i[DATA_W-2:0], carry_i};
        carry_o  = acc_i[DATA_W-1];
      end
      OP_ROR: begin
        result_o = {carry_i, acc_i[DATA_W-1:1]};
        carry_o  = acc_i[0];
      end
`endif
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/acc_cpu_core.sv
// acc_cpu_core
// Single-accumulator CPU core with a small scratch memory. One instruction
// is accepted in IDLE, executed in EXEC (all state commits on that edge)
// and reported with a one-cycle done pulse in DONE.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : acc_cpu_if.slave (instruction handshake + status outputs)
// Optional feature macro: ACC_CPU_ROTATE_EN (handled inside acc_cpu_alu).
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W_DEF,
  parameter int ADDR_W = ACC_ADDR_W_DEF
) (
  input  logic      clk,
  input  logic      rst,
  acc_cpu_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t            state_q, state_d;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] operand_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] acc_q;
  logic              c_q, z_q, err_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry, alu_illegal;

  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i      (op_q),
    .acc_i     (acc_q),
    .operand_i (operand_q),
    .mem_i     (mem_q[addr_q]),
    .carry_i   (c_q),
    .result_o  (alu_result),
    .carry_o   (alu_carry),
    .illegal_o (alu_illegal)
  );

  // Fixed three-state sequence; only the IDLE exit waits on the producer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.instr_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Latch the instruction on acceptance so the producer may change it later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      operand_q <= '0;
      addr_q    <= '0;
    end else if (state_q == ST_IDLE && bus.instr_valid) begin
      op_q      <= bus.instr_op;
      operand_q <= bus.instr_operand;
      addr_q    <= bus.instr_addr;
    end
  end

  // Illegal opcodes leave acc and flags untouched; STORE keeps acc and Z
  // while the ALU hands back the old carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      c_q   <= 1'b0;
      z_q   <= 1'b1;
      err_q <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      err_q <= alu_illegal;
      if (!alu_illegal) begin
        c_q <= alu_carry;
        if (op_q != OP_STORE) begin
          acc_q <= alu_result;
          z_q   <= (alu_result == '0);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == ST_EXEC && op_q == OP_STORE) begin
      mem_q[addr_q] <= acc_q;
    end
  end

  assign bus.instr_ready = (state_q == ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.err         = err_q & (state_q == ST_DONE);
  assign bus.acc_out     = acc_q;
  assign bus.flag_c      = c_q;
  assign bus.flag_z      = z_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// tb_acc_cpu_core
// Directed bench for acc_cpu_core (DATA_W=8, ADDR_W=4). The driver pushes
// the hand-computed result of each instruction into a queue when it is
// accepted; a monitor pops and compares whenever done is seen.
// Honours ACC_CPU_ROTATE_EN for the expected rotate results.
module tb_acc_cpu_core;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  typedef struct {
    string      tag;
    logic [7:0] acc;
    logic       c;
    logic       z;
    logic       err;
    int         acceptCyc;
  } exp_t;

  exp_t expQ[$];
  exp_t expCur;

  acc_cpu_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  acc_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Offer one instruction, hold it until accepted (plus holdCycles extra
  // cycles), and queue the expected result unless it is to be aborted by
  // a reset asserted during EXEC.
  task automatic applyStimulus(input string tag, input logic [3:0] op,
                               input logic [7:0] operand, input logic [3:0] addr,
                               input logic [7:0] eAcc, input logic eC, input logic eZ,
                               input logic eErr, input int holdCycles, input bit abortExec);
    int   waitCnt;
    bit   accepted;
    exp_t e;
    waitCnt  = 0;
    accepted = 0;
    @(negedge clk);
    bus.instr_valid   = 1'b1;
    bus.instr_op      = op;
    bus.instr_operand = operand;
    bus.instr_addr    = addr;
    while (!accepted && waitCnt < 20) begin
      if (bus.instr_ready) begin
        accepted = 1;
        if (!abortExec) begin
          e.tag = tag; e.acc = eAcc; e.c = eC; e.z = eZ; e.err = eErr; e.acceptCyc = cyc;
          expQ.push_back(e);
        end
      end else begin
        @(negedge clk);
        waitCnt++;
      end
    end
    if (!accepted) begin
      checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
      bus.instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (abortExec) begin
      bus.instr_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checkOutput({tag, "_rst_done"}, bus.done, 1'b0);
      checkOutput({tag, "_rst_ready"}, bus.instr_ready, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_post_ready"}, bus.instr_ready, 1'b1);
      checkOutput({tag, "_post_acc"}, bus.acc_out, 8'h00);
      checkOutput({tag, "_post_done"}, bus.done, 1'b0);
    end else begin
      repeat (holdCycles) @(posedge clk);
      if (holdCycles > 0) #1;
      bus.instr_valid = 1'b0;
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done actual=done expected=no_done acc=0x%0h", bus.acc_out);
      end else begin
        expCur = expQ.pop_front();
        checkOutput({expCur.tag, "_acc"}, bus.acc_out, expCur.acc);
        checkOutput({expCur.tag, "_c"}, bus.flag_c, expCur.c);
        checkOutput({expCur.tag, "_z"}, bus.flag_z, expCur.z);
        checkOutput({expCur.tag, "_err"}, bus.err, expCur.err);
        checkOutput({expCur.tag, "_latency"}, cyc - expCur.acceptCyc, 2);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int drainCnt;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.instr_valid   = 1'b0;
    bus.instr_op      = 4'h0;
    bus.instr_operand = 8'h00;
    bus.instr_addr    = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_acc", bus.acc_out, 8'h00);
    checkOutput("reset_z", bus.flag_z, 1'b1);
    checkOutput("reset_c", bus.flag_c, 1'b0);
    checkOutput("reset_ready", bus.instr_ready, 1'b1);
    checkOutput("reset_done", bus.done, 1'b0);

    //             tag          op    imm    addr  acc    C     Z     err   hold abort
    applyStimulus("load7_rst",  4'h3, 8'h00, 4'h7, 8'h00, 1'b0, 1'b1, 1'b0, 0, 0);
    applyStimulus("loadi_f0",   4'h4, 8'hF0, 4'h0, 8'hF0, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus("add_wrap",   4'h0, 8'h20, 4'h0, 8'h10, 1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus("loadi_05",   4'h4, 8'h05, 4'h0, 8'h05, 1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus("store3",     4'h2, 8'h00, 4'h3, 8'h05, 1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus("loadi_00",   4'h4, 8'h00, 4'h0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 0);
    applyStimulus("load3",      4'h3, 8'h00, 4'h3, 8'h05, 1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus("addm3",      4'hB, 8'h00, 4'h3, 8'h0A, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus("loadi_03",   4'h4, 8'h03, 4'h0, 8'h03, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus("sub_zero",   4'h1, 8'h03, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 0);
    applyStimulus("sub_borrow", 4'h1, 8'h01, 4'h0, 8'hFF, 1'b1, 1'b0, 1'b0, 2, 0);
    applyStimulus("and_0f",     4'h5, 8'h0F, 4'h0, 8'h0F, 1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus("or_30",      4'h6, 8'h30, 4'h0, 8'h3F, 1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus("xor_ff",     4'h7, 8'hFF, 4'h0, 8'hC0, 1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus("not",        4'h8, 8'h00, 4'h0, 8'h3F, 1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus("shl",        4'h9, 8'h00, 4'h0, 8'h7E, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus("shr_c0",     4'hA, 8'h00, 4'h0, 8'h3F, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus("shr_c1",     4'hA, 8'h00, 4'h0, 8'h1F, 1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus("illegal_e",  4'hE, 8'h55, 4'h0, 8'h1F, 1'b1, 1'b0, 1'b1, 0, 0);
    applyStimulus("loadi_81",   4'h4, 8'h81, 4'h0, 8'h81, 1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus("add_00",     4'h0, 8'h00, 4'h0, 8'h81, 1'b0, 1'b0, 1'b0, 0, 0);
`ifdef ACC_CPU_ROTATE_EN
    applyStimulus("rol",        4'hC, 8'h00, 4'h0, 8'h02, 1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus("ror",        4'hD, 8'h00, 4'h0, 8'h81, 1'b0, 1'b0, 1'b0, 0, 0);
`else
    applyStimulus("rol_illegal", 4'hC, 8'h00, 4'h0, 8'h81, 1'b0, 1'b0, 1'b1, 0, 0);
    applyStimulus("ror_illegal", 4'hD, 8'h00, 4'h0, 8'h81, 1'b0, 1'b0, 1'b1, 0, 0);
`endif
    applyStimulus("loadi_33",   4'h4, 8'h33, 4'h0, 8'h33, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus("store5_abort", 4'h2, 8'h00, 4'h5, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1);
    applyStimulus("load5_after", 4'h3, 8'h00, 4'h5, 8'h00, 1'b0, 1'b1, 1'b0, 0, 0);

    drainCnt = 0;
    while (expQ.size() != 0 && drainCnt < 50) begin
      @(negedge clk);
      drainCnt++;
    end
    repeat (4) @(negedge clk);
    checkOutput("drain_pending", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_cpu_core.md
ACC_CPU_CORE -- requirements
Module: acc_cpu_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, accumulator/operand/memory word width (>=4).
REQ-002 SHALL have parameter ADDR_W, default 4, scratch-memory address width; depth = 2**ADDR_W words.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port instr_valid  input  1  instruction offered.
REQ-006 SHALL have port instr_ready  output  1  core can accept an instruction.
REQ-007 SHALL have port instr_op  input  4  opcode.
REQ-008 SHALL have port instr_operand  input  DATA_W  immediate operand.
REQ-009 SHALL have port instr_addr  input  ADDR_W  memory address.
REQ-010 SHALL have port acc_out  output  DATA_W  accumulator value.
REQ-011 SHALL have port flag_c  output  1  carry/borrow/shifted-out bit.
REQ-012 SHALL have port flag_z  output  1  accumulator-zero flag.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port err  output  1  illegal-opcode indication, valid only with done.

Function
REQ-015 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; no other states reachable.
REQ-016 SHALL drive instr_ready=1 only in IDLE; accept on the edge where instr_valid && instr_ready, latching op/operand/addr, IDLE->EXEC.
REQ-017 SHALL ignore instr_valid in EXEC and DONE; the producer holds its request.
REQ-018 SHALL commit acc/flags/memory on the EXEC edge (EXEC->DONE); done=1 during DONE only; DONE->IDLE unconditionally; accept-to-done latency 2 cycles, throughput 1 instruction per 3 cycles.
REQ-019 SHALL decode: 0 ADD acc+imm; 1 SUB acc-imm; 2 STORE mem[addr]=acc; 3 LOAD acc=mem[addr]; 4 LOADI acc=imm; 5 AND; 6 OR; 7 XOR (acc op imm); 8 NOT acc; 9 SHL acc<<1; A SHR acc>>1 (logical); B ADDM acc+mem[addr].
REQ-020 SHALL wrap all arithmetic modulo 2**DATA_W; ADD/ADDM flag_c = carry-out; SUB flag_c = borrow (imm > acc).
REQ-021 SHALL set flag_c on SHL to old acc MSB and on SHR to old acc LSB.
REQ-022 SHALL leave flag_c unchanged for LOAD, LOADI, logic ops, NOT, and STORE.
REQ-023 SHALL update flag_z from the new acc on every acc-writing op; STORE leaves all flags and acc unchanged.
REQ-024 SHALL treat undefined opcodes as no-ops: acc, flags, memory unchanged; err=1 together with done.
REQ-025 SHALL drive acc_out, flag_c, flag_z directly from registers.

Reset
REQ-026 SHALL on rst clear acc, flag_c, all memory words and err, set flag_z=1, done=0, state=IDLE (instr_ready=1 once rst deasserts).
REQ-027 SHALL abort any in-flight instruction on rst with no memory/acc write and no done pulse.

Configuration
REQ-028 SHALL honour macro ACC_CPU_ROTATE_EN: when defined, opcode C = ROL through carry {acc,c} rotate left, D = ROR through carry; when undefined, C and D are illegal per REQ-024.

Structure
REQ-029 SHALL place opcode constants, FSM state typedef and DATA_W/ADDR_W defaults in package acc_cpu_pkg.
REQ-030 SHALL implement the datapath as combinational sub-module acc_cpu_alu (inputs op, acc, operand, mem word, carry; outputs result, carry, illegal).

Verification (DATA_W=8, ADDR_W=4)
REQ-031 SHALL cover reset: after rst, acc_out=0x00, flag_z=1, flag_c=0, instr_ready=1, LOAD of any address returns 0x00.
REQ-032 SHALL cover ADD wrap: LOADI 0xF0, ADD 0x20 -> acc 0x10, C=1, Z=0, done exactly 2 cycles after accept.
REQ-033 SHALL cover memory: LOADI 0x05, STORE 3, LOADI 0x00, LOAD 3 -> 0x05; ADDM 3 -> 0x0A, C=0.
REQ-034 SHALL cover SUB: acc 0x03 SUB 0x03 -> 0x00 Z=1 C=0; then SUB 0x01 -> 0xFF C=1 Z=0; instr_valid held through EXEC/DONE accepted only once.
REQ-035 SHALL cover opcode 0xE -> done with err=1, acc unchanged; with ACC_CPU_ROTATE_EN, acc 0x81 C=0 ROL -> 0x02 C=1, without it opcode C -> err=1.
REQ-036 SHALL cover rst asserted during EXEC of STORE 5 -> mem[5]=0x00, no done, FSM IDLE.
